// File: rtl/card_pkg.sv
// card_pkg: card grid geometry, FSM state encoding, map cell accessor and row top helper
package card_pkg;
  localparam int CARD_EMPTY = 54;
  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 18;
  localparam int CELLS = GRID_ROWS * GRID_COLS;
  localparam int CELL_W = 32;
  localparam int CELL_H = 46;
  localparam int ROW_PITCH = 55;
  localparam int GRID_X0 = 32;
  localparam int GRID_X_END = 607;
  localparam int GRID_Y0 = 19;
  localparam int GRID_Y_LOW = 360;
  typedef enum logic [1:0] {IDLE, DECODE, APPLY, CLEAR} state_t;
  function automatic logic [5:0] cell_of(input logic [6*CELLS-1:0] m, input logic [7:0] i);
    return m[10'(i)*10'd6 +: 6];
  endfunction
  function automatic int row_top(input int r);
    return r < 6 ? GRID_Y0 + ROW_PITCH * r : GRID_Y_LOW + ROW_PITCH * (r - 6);
  endfunction
endpackage

// File: rtl/card_sel_ctrl_if.sv
// card_sel_ctrl_if: mouse/button/map inputs and selection/hover outputs of card_sel_ctrl; master drives inputs, slave is the controller
interface card_sel_ctrl_if;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic l_click;
  logic r_click;
  logic clear_all;
  logic sel_enable;
  logic [6*card_pkg::CELLS-1:0] map;
  logic [card_pkg::CELLS-1:0] sel_card;
  logic [7:0] sel_count;
  logic [7:0] hover_pos;
  logic hover_valid;
  logic sel_changed;
  modport master (
    output mouse_x, mouse_y, l_click, r_click, clear_all, sel_enable, map,
    input sel_card, sel_count, hover_pos, hover_valid, sel_changed
  );
  modport slave (
    input mouse_x, mouse_y, l_click, r_click, clear_all, sel_enable, map,
    output sel_card, sel_count, hover_pos, hover_valid, sel_changed
  );
endinterface

// File: rtl/card_grid_decode.sv
// card_grid_decode: combinational pixel to card cell decode; in x,y (10b); out row (3b), col (5b), pos=row*18+col (8b), valid
module card_grid_decode import card_pkg::*; (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [2:0] row,
  output logic [4:0] col,
  output logic [7:0] pos,
  output logic       valid
);
  logic rv;
  assign col = 5'((x - 10'(GRID_X0)) >> 5);
  always_comb begin
    row = '0;
    rv = 1'b0;
    for (int r = 0; r < GRID_ROWS; r++)
      if ({22'b0, y} >= row_top(r) && {22'b0, y} < row_top(r) + CELL_H) begin
        row = 3'(r);
        rv = 1'b1;
      end
  end
  assign valid = rv && x >= 10'(GRID_X0) && x < 10'(GRID_X_END);
  assign pos = 8'(row) * 8'(GRID_COLS) + 8'(col);
endmodule

// File: rtl/card_sel_ctrl.sv
// card_sel_ctrl: mouse-driven card selection with clear, MAX_SEL limit and empty-cell sweep; ports clk, rst, bus (card_sel_ctrl_if.slave)
module card_sel_ctrl import card_pkg::*; #(
  parameter int   MAX_SEL = 144,
  parameter logic SCAN_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  card_sel_ctrl_if.slave bus
);
  state_t state, nstate;
  logic l_d, r_d, l_rise, r_rise, clr_pend, latch, in_apply, in_clear;
  logic [9:0] lx, ly;
  logic [7:0] pos_q, scan_idx, hpos, cpos, sel_count, cnt_n, hover_pos;
  logic valid_q, hval, cval, hover_valid, sel_changed;
  logic [CELLS-1:0] sel_card, sel_n;
  logic [2:0] hrow_unused, crow_unused;
  logic [4:0] hcol_unused, ccol_unused;
  logic scan_hit, app_hit, app_set, app_clr;
  card_grid_decode u_hover (.x(bus.mouse_x), .y(bus.mouse_y), .row(hrow_unused), .col(hcol_unused), .pos(hpos), .valid(hval));
  card_grid_decode u_click (.x(lx), .y(ly), .row(crow_unused), .col(ccol_unused), .pos(cpos), .valid(cval));
  assign l_rise = bus.l_click & ~l_d;
  assign r_rise = bus.r_click & ~r_d;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nstate;
  always_comb
    nstate = state == IDLE ? ((clr_pend | bus.clear_all | r_rise) ? CLEAR :
                              (l_rise & bus.sel_enable) ? DECODE : IDLE) :
             state == DECODE ? APPLY : IDLE;
  always_comb begin
    latch = state == IDLE && nstate == DECODE;
    in_apply = state == APPLY;
    in_clear = state == CLEAR;
  end
  // sweep and toggle may hit different cells in one cycle; count takes the net delta
  always_comb begin
    scan_hit = SCAN_EN && !in_clear && cell_of(bus.map, scan_idx) == 6'(CARD_EMPTY) && sel_card[scan_idx];
    app_hit = in_apply && valid_q && cell_of(bus.map, pos_q) != 6'(CARD_EMPTY) &&
              (sel_card[pos_q] || sel_count < 8'(MAX_SEL));
    app_set = app_hit && !sel_card[pos_q];
    app_clr = app_hit && sel_card[pos_q];
    sel_n = sel_card;
    if (scan_hit) sel_n[scan_idx] = 1'b0;
    if (app_hit) sel_n[pos_q] = app_set;
    if (in_clear) sel_n = '0;
    cnt_n = in_clear ? 8'd0 : sel_count + 8'(app_set) - 8'(app_clr) - 8'(scan_hit);
  end
  always_ff @(posedge clk)
    if (rst) begin
      l_d <= 1'b0;
      r_d <= 1'b0;
      lx <= '0;
      ly <= '0;
      pos_q <= '0;
      valid_q <= 1'b0;
      clr_pend <= 1'b0;
      scan_idx <= '0;
      sel_card <= '0;
      sel_count <= '0;
      sel_changed <= 1'b0;
      hover_pos <= '0;
      hover_valid <= 1'b0;
    end else begin
      l_d <= bus.l_click;
      r_d <= bus.r_click;
      if (latch) begin
        lx <= bus.mouse_x;
        ly <= bus.mouse_y;
      end
      pos_q <= cval ? cpos : 8'd0;
      valid_q <= cval;
      clr_pend <= in_clear ? 1'b0 : clr_pend | (state != IDLE && bus.clear_all);
      scan_idx <= in_clear ? scan_idx : scan_idx == 8'(CELLS - 1) ? 8'd0 : scan_idx + 8'd1;
      sel_card <= sel_n;
      sel_count <= cnt_n;
      sel_changed <= sel_n != sel_card;
      hover_pos <= hval ? hpos : 8'd0;
      hover_valid <= hval;
    end
  assign bus.sel_card = sel_card;
  assign bus.sel_count = sel_count;
  assign bus.hover_pos = hover_pos;
  assign bus.hover_valid = hover_valid;
  assign bus.sel_changed = sel_changed;
endmodule

// File: tb/tb_card_sel_ctrl.sv
// tb_card_sel_ctrl: directed and random checks of two card_sel_ctrl instances (MAX_SEL 144 and 3) against a transaction-level model
module tb_card_sel_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [9:0] mx = '0, my = '0;
  logic lc = 1'b0, rc = 1'b0, ca = 1'b0, en = 1'b1;
  logic [863:0] mp = '0;
  logic [143:0] sc[2];
  logic [7:0] cn[2], hp[2];
  logic hv[2], ch[2];
  int checks = 0, errors = 0;
  for (genvar g = 0; g < 2; g++) begin : gi
    card_sel_ctrl_if bus ();
    assign bus.mouse_x = mx;
    assign bus.mouse_y = my;
    assign bus.l_click = lc;
    assign bus.r_click = rc;
    assign bus.clear_all = ca;
    assign bus.sel_enable = en;
    assign bus.map = mp;
    assign sc[g] = bus.sel_card;
    assign cn[g] = bus.sel_count;
    assign hp[g] = bus.hover_pos;
    assign hv[g] = bus.hover_valid;
    assign ch[g] = bus.sel_changed;
    card_sel_ctrl #(.MAX_SEL(g ? 3 : 144), .SCAN_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  end
  task automatic chk(input string n, input logic [143:0] a, input logic [143:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask
  function automatic void mdec(input int x, input int y, output bit v, output int p);
    int r, off;
    v = 0; p = 0; r = 0; off = 99;
    if (y >= 19 && y < 19 + 6 * 55) begin r = (y - 19) / 55; off = (y - 19) % 55; end
    else if (y >= 360 && y < 360 + 2 * 55) begin r = 6 + (y - 360) / 55; off = (y - 360) % 55; end
    if (x >= 32 && x < 607 && off <= 45) begin v = 1; p = r * 18 + (x - 32) / 32; end
  endfunction
  function automatic int mcell(input int i);
    return int'(mp[6*i +: 6]);
  endfunction
  int cyc = 0, busy_until = 0, apply_at = -1, clear_at = -1, sidx = 0, mhp = 0;
  int mc[2], oc, mp_pos;
  bit pend, ld, rd, mhv, idle, mv;
  bit mchg[2];
  logic [143:0] ms[2], old;
  int lx, ly;
  always @(posedge clk) begin
    if (rst) begin
      busy_until = 0; apply_at = -1; clear_at = -1; pend = 0; ld = 0; rd = 0;
      sidx = 0; mhp = 0; mhv = 0;
      for (int k = 0; k < 2; k++) begin ms[k] = '0; mc[k] = 0; mchg[k] = 0; end
    end else begin
      idle = cyc >= busy_until;
      for (int k = 0; k < 2; k++) begin
        old = ms[k]; oc = mc[k];
        if (clear_at == cyc) begin ms[k] = '0; mc[k] = 0; end
        else begin
          if (mcell(sidx) == 54 && old[sidx]) begin ms[k][sidx] = 1'b0; mc[k]--; end
          if (apply_at == cyc) begin
            mdec(lx, ly, mv, mp_pos);
            if (mv && mcell(mp_pos) != 54 && (old[mp_pos] || oc < (k ? 3 : 144))) begin
              ms[k][mp_pos] = !old[mp_pos];
              mc[k] += old[mp_pos] ? -1 : 1;
            end
          end
        end
        mchg[k] = ms[k] != old;
      end
      if (clear_at == cyc) pend = 0;
      else if (!idle && ca) pend = 1;
      if (idle) begin
        if (pend || ca || (rc && !rd)) begin clear_at = cyc + 1; busy_until = cyc + 2; end
        else if (lc && !ld && en) begin lx = mx; ly = my; apply_at = cyc + 2; busy_until = cyc + 3; end
      end
      if (clear_at != cyc) sidx = (sidx + 1) % 144;
      mdec(mx, my, mv, mp_pos);
      mhv = mv;
      mhp = mv ? mp_pos : 0;
      ld = lc; rd = rc;
    end
    cyc++;
  end
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sel_card[%0d]", k), sc[k], ms[k]);
      chk($sformatf("sel_count[%0d]", k), 144'(cn[k]), 144'(mc[k]));
      chk($sformatf("sel_changed[%0d]", k), 144'(ch[k]), 144'(mchg[k]));
      chk($sformatf("hover_pos[%0d]", k), 144'(hp[k]), 144'(mhp));
      chk($sformatf("hover_valid[%0d]", k), 144'(hv[k]), 144'(mhv));
    end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic click(input int p);
    int r;
    r = p / 18;
    mx = 10'(40 + 32 * (p % 18));
    my = 10'((r < 6 ? 19 + 55 * r : 360 + 55 * (r - 6)) + 5);
    lc = 1'b1; step(1); lc = 1'b0; step(4);
  endtask
  task automatic click_xy(input int x, input int y);
    mx = 10'(x); my = 10'(y);
    lc = 1'b1; step(1); lc = 1'b0; step(4);
  endtask
  initial begin
    int c;
    for (int i = 0; i < 144; i++) mp[6*i +: 6] = 6'd5;
    step(2);
    rst = 1'b0;
    chk("rst_sel", sc[0], 0);
    chk("rst_cnt", 144'(cn[0]), 0);
    chk("rst_hv", 144'(hv[0]), 0);
    chk("rst_chg", 144'(ch[0]), 0);
    click_xy(40, 20);
    chk("tog_bit0", 144'(sc[0][0]), 1);
    chk("tog_cnt", 144'(cn[0]), 1);
    click_xy(40, 20);
    chk("untog_bit0", 144'(sc[0][0]), 0);
    chk("untog_cnt", 144'(cn[0]), 0);
    click_xy(100, 67);
    click_xy(607, 20);
    click_xy(20, 20);
    chk("invalid_sel", sc[0], 0);
    mx = 10'd600; my = 10'd365; step(1);
    chk("hover_pos", 144'(hp[0]), 125);
    chk("hover_valid", 144'(hv[0]), 1);
    for (int i = 0; i < 4; i++) click(i);
    chk("lim_bit3", 144'(sc[1][3]), 0);
    chk("lim_cnt", 144'(cn[1]), 3);
    chk("nolim_cnt", 144'(cn[0]), 4);
    click(1);
    click(3);
    chk("lim_bit3_after", 144'(sc[1][3]), 1);
    chk("lim_cnt_after", 144'(cn[1]), 3);
    mp[6*5 +: 6] = 6'd54;
    click(5);
    chk("empty_click", 144'(sc[0][5]), 0);
    click(20);
    chk("bit20_set", 144'(sc[0][20]), 1);
    mp[6*20 +: 6] = 6'd54;
    step(150);
    chk("bit20_swept", 144'(sc[0][20]), 0);
    chk("swept_cnt", 144'(cn[0]), 2);
    click(7 - 7);
    click(0);
    mx = 10'(40 + 32 * 7); my = 10'd24;
    lc = 1'b1; ca = 1'b1; step(1); lc = 1'b0; ca = 1'b0; step(4);
    chk("clr_prio0", sc[0], 0);
    chk("clr_prio1", sc[1], 0);
    mx = 10'd40; my = 10'd20;
    lc = 1'b1; step(1); lc = 1'b0; step(1); ca = 1'b1; step(1); ca = 1'b0;
    chk("apply_before_clr", 144'(sc[0][0]), 1);
    step(2);
    chk("clr_in_apply", sc[0], 0);
    click(4);
    chk("bit4_set", 144'(sc[0][4]), 1);
    rc = 1'b1; step(3); rc = 1'b0;
    chk("rclick_clr", sc[0], 0);
    for (int i = 0; i < 144; i++) mp[6*i +: 6] = $urandom_range(0, 4) == 0 ? 6'd54 : 6'($urandom_range(0, 53));
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        c = $urandom_range(0, 143);
        mx = 10'(40 + 32 * (c % 18));
        my = 10'((c / 18 < 6 ? 19 + 55 * (c / 18) : 360 + 55 * (c / 18 - 6)) + $urandom_range(0, 45));
      end else begin
        mx = 10'($urandom_range(0, 639));
        my = 10'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 2) == 0) lc = ~lc;
      rc = $urandom_range(0, 60) == 0;
      ca = $urandom_range(0, 80) == 0;
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 15) == 0) begin
        c = $urandom_range(0, 143);
        mp[6*c +: 6] = $urandom_range(0, 3) == 0 ? 6'd54 : 6'($urandom_range(0, 53));
      end
      rst = $urandom_range(0, 999) == 0;
      step(1);
    end
    rst = 1'b0; lc = 1'b0; rc = 1'b0; ca = 1'b0;
    step(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/card_sel_ctrl.md
Name: card_sel_ctrl

Overview:
Upstream producer of the per-cell selection vector consumed by the board card renderer. Converts mouse position and button levels into toggled selection bits over the 8x18 card grid, keeps selections consistent with the card map, and reports the cell under the cursor. Runs in the system clock domain and feeds sel_card and hover_pos to the display path.

Parameters:
MAX_SEL, 144, maximum number of simultaneously selected cells (1..144)
SCAN_EN, 1, enables the background sweep that clears selections on empty cells

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
mouse_x  in  10  cursor x in screen pixels
mouse_y  in  10  cursor y in screen pixels
l_click  in  1  left button level
r_click  in  1  right button level (clear all selections)
clear_all  in  1  one-cycle clear request from game control
sel_enable  in  1  left-click selection allowed when high
map  in  864  card table, cell i = map[6i+5:6i], 54 = empty
sel_card  out  144  selection bit per cell, index = row*18+col
sel_count  out  8  number of set bits in sel_card
hover_pos  out  8  cell index under cursor
hover_valid  out  1  cursor is inside a card cell
sel_changed  out  1  one-cycle pulse after any sel_card update

Behaviour:
- Reset (rst high at a clk edge): sel_card=0, sel_count=0, hover_pos=0, hover_valid=0, sel_changed=0, FSM=IDLE, scan_idx=0, click history regs=0, clear pending=0. Reset mid-operation aborts any in-flight toggle.
- Grid decode: column c=(x-32)>>5 valid for 32<=x<607. Row r valid when y is in [19+55r, 19+55r+45] for r=0..5, or in [360+55(r-6), 360+55(r-6)+45] for r=6,7. Pixels in inter-row gaps or outside these ranges are invalid. pos=r*18+c.
- Hover: hover_pos/hover_valid registered from decode(mouse_x, mouse_y) every cycle; 1-cycle latency. When invalid, hover_pos holds 0.
- Edge detect: l_rise = l_click & ~l_click_d. r_rise is formed the same way from r_click.
- FSM IDLE -> DECODE -> APPLY -> IDLE. CLEAR is entered from IDLE.
- IDLE priority:
  - clear pending, clear_all or r_rise -> CLEAR.
  - Else l_rise & sel_enable -> DECODE, latching mouse_x/mouse_y.
- DECODE: registers pos/valid from the latched coordinates.
- APPLY: toggle takes effect iff valid and map cell != 54 and (bit set, or sel_count < MAX_SEL).
- CLEAR: sel_card <= 0, sel_count <= 0, clears pending, then -> IDLE.
- Latency: rise sampled at edge E0; sel_card/sel_count update at edge E2; sel_changed high for the cycle after E2. sel_changed only pulses when a bit actually changes.
- Clicks arriving outside IDLE are dropped. clear_all outside IDLE sets clear pending, serviced on return to IDLE.
- Background scan (SCAN_EN=1):
  - scan_idx advances 0..143 then wraps to 0, one cell per cycle in all states except CLEAR.
  - If the cell is 54 and its bit is set, the bit is cleared and sel_changed pulses.
  - Scan and APPLY hitting different cells in the same cycle: both take effect, and sel_count applies the net delta (-2..+1).
  - Same cell in the same cycle: APPLY cannot set an empty cell, so scan's clear wins.
- sel_count is maintained incrementally and never exceeds MAX_SEL. It is 8-bit, max 144.
- sel_enable low: left clicks are ignored; clear and scan still operate.

Decomposition:
- Shared package card_pkg holds the constants: CARD_EMPTY=54, GRID_ROWS=8, GRID_COLS=18, CELL_W=32, CELL_H=46, ROW_PITCH=55, GRID_X0=32, GRID_X_END=607, GRID_Y0=19, GRID_Y_LOW=360, and the FSM state encoding.
- Sub-module card_grid_decode: combinational (x,y) -> row, col, pos, valid. Instantiated twice (hover, click), and reusable by the renderer.

Test Plan:
- Reset: rst for 2 cycles -> sel_card=0, sel_count=0, hover_valid=0, sel_changed=0.
- Toggle:
  - map[0]=5, mouse (40,20), l_click 0->1 -> at E2 sel_card[0]=1, sel_count=1, one sel_changed pulse.
  - Repeat the click -> sel_card[0]=0, sel_count=0.
- Invalid positions: clicks at (100,67) (row gap), (607,20) and (20,20) -> no change, no sel_changed. Hover at (600,365) -> hover_pos=125, hover_valid=1 one cycle later.
- Limit, with MAX_SEL=3:
  - Select cells 0,1,2, then click cell 3 -> bit 3 stays 0, sel_count=3.
  - Deselect cell 1, then click cell 3 -> bit 3=1.
- Empty cells:
  - Click on a cell holding 54 -> no change.
  - Selected cell 20 changed to 54 -> bit 20 cleared within 144 cycles, sel_count decremented once.
- Clear priority:
  - clear_all and l_rise in the same IDLE cycle -> sel_card=0, click dropped.
  - clear_all during APPLY -> cleared two cycles later.
  - r_click rise -> sel_card=0.
